// File: rtl/key_event_classifier_pkg.sv
// Shared definitions for the key event classifier: FSM state encodings
// (IDLE=0, PRESS1=1, WAIT2=2, PRESS2=3, HELD=4), also used by menu logic
// to decode the debug state output.
package key_event_classifier_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE   = 3'd0,
        PRESS1 = 3'd1,
        WAIT2  = 3'd2,
        PRESS2 = 3'd3,
        HELD   = 3'd4
    } key_state_e;

endpackage

// File: rtl/key_event_classifier_if.sv
// Debounced-key link: debouncer (master) drives pressed/change, the
// classifier (slave) returns gesture pulses and its debug state.
interface key_event_if;
    import key_event_classifier_pkg::*;

    logic               pressed;
    logic               change;
    logic               short_press;
    logic               double_press;
    logic               long_press;
    logic               repeat_press;
    logic [STATE_W-1:0] state;

    modport master (
        output pressed, change,
        input  short_press, double_press, long_press, repeat_press, state
    );

    modport slave (
        input  pressed, change,
        output short_press, double_press, long_press, repeat_press, state
    );
endinterface

// File: rtl/key_event_classifier_ms_tick_sync.sv
// ms_tick_sync: brings the asynchronous 1 ms square wave into the clk
// domain through two flops and emits a one-cycle pulse per rising edge.
module ms_tick_sync (
    input  logic clk,
    input  logic resetn,
    input  logic clk_ms,
    output logic ms_tick
);
    // sh[1:0] is the synchronizer, sh[2] holds the previous synced level
    logic [2:0] sh;

    // Shift the raw square wave through sync and edge-history flops
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) sh <= '0;
        else         sh <= {sh[1:0], clk_ms};
    end

    assign ms_tick = sh[1] & ~sh[2];
endmodule

// File: rtl/key_event_classifier.sv
// key_event_classifier: turns debounced press/release events into
// one-cycle short / double / long / auto-repeat pulses, timed by ms ticks.
// Optional feature macro: KEY_REPEAT_EN enables repeat_press in HELD;
// without it repeat_press stays 0 and HELD just waits for release.
module key_event_classifier
    import key_event_classifier_pkg::*;
#(
    parameter int LONG_MS   = 1000,
    parameter int DOUBLE_MS = 300,
    parameter int REPEAT_MS = 200,
    parameter int CNT_W     = 16
) (
    input  logic     clk,
    input  logic     resetn,
    input  logic     clk_ms,
    key_event_if.slave bus
);
`ifdef KEY_REPEAT_EN
    localparam bit REPEAT_EN = 1'b1;
`else
    localparam bit REPEAT_EN = 1'b0;
`endif

    // Timeout X fires on the X-th tick after state entry, i.e. cnt == X-1
    localparam logic [CNT_W-1:0] LONG_LIM   = CNT_W'(LONG_MS - 1);
    localparam logic [CNT_W-1:0] DOUBLE_LIM = CNT_W'(DOUBLE_MS - 1);
    localparam logic [CNT_W-1:0] REPEAT_LIM = CNT_W'(REPEAT_MS - 1);

    logic ms_tick;

    ms_tick_sync u_tick (
        .clk     (clk),
        .resetn  (resetn),
        .clk_ms  (clk_ms),
        .ms_tick (ms_tick)
    );

    key_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             cnt_clr;
    logic             short_d, double_d, long_d, repeat_d;
    logic             short_q, double_q, long_q, repeat_q;

    logic press_ev, rel_ev;
    logic to_long, to_double, to_repeat;

    assign press_ev  = bus.change &  bus.pressed;
    assign rel_ev    = bus.change & ~bus.pressed;
    assign to_long   = ms_tick && (cnt_q == LONG_LIM);
    assign to_double = ms_tick && (cnt_q == DOUBLE_LIM);
    assign to_repeat = ms_tick && (cnt_q == REPEAT_LIM);

    // Next state and pulse decode; edge events are checked before timeouts
    always_comb begin
        state_d  = state_q;
        cnt_clr  = 1'b0;
        short_d  = 1'b0;
        double_d = 1'b0;
        long_d   = 1'b0;
        repeat_d = 1'b0;
        case (state_q)
            IDLE:   if (press_ev) state_d = PRESS1;
            PRESS1: begin
                if (rel_ev) state_d = WAIT2;
                else if (to_long) begin
                    long_d  = 1'b1;
                    state_d = HELD;
                end
            end
            WAIT2: begin
                if (press_ev) state_d = PRESS2;
                else if (to_double) begin
                    short_d = 1'b1;
                    state_d = IDLE;
                end
            end
            PRESS2: begin
                // a second press never yields long_press, even when held
                if (rel_ev) begin
                    double_d = 1'b1;
                    state_d  = IDLE;
                end else if (to_long) begin
                    double_d = 1'b1;
                    state_d  = HELD;
                end
            end
            HELD: begin
                if (rel_ev) state_d = IDLE;
                else if (REPEAT_EN && to_repeat) begin
                    repeat_d = 1'b1;
                    cnt_clr  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_d != state_q) cnt_clr = 1'b1;
    end

    // State register and registered one-cycle output pulses
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            short_q  <= 1'b0;
            double_q <= 1'b0;
            long_q   <= 1'b0;
            repeat_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            short_q  <= short_d;
            double_q <= double_d;
            long_q   <= long_d;
            repeat_q <= repeat_d;
        end
    end

    // ms counter: cleared on state entry / repeat restart, saturating
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                     cnt_q <= '0;
        else if (cnt_clr)                cnt_q <= '0;
        else if (ms_tick && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
    end

    assign bus.short_press  = short_q;
    assign bus.double_press = double_q;
    assign bus.long_press   = long_q;
    assign bus.repeat_press = repeat_q;
    assign bus.state        = state_q;
endmodule

// File: tb/tb_key_event_classifier.sv
// Directed bench for key_event_classifier with LONG_MS=10, DOUBLE_MS=5,
// REPEAT_MS=3 and clk_ms period of 20 clk. clk_ms is derived from a free
// cycle counter, so the DUT's ms tick is visible in cycles with cyc%20==12
// (rise when cyc%20 becomes 10, plus two synchronizer flops).
module tb_key_event_classifier;
    import key_event_classifier_pkg::*;

`ifdef KEY_REPEAT_EN
    localparam int REP_EN = 1;
`else
    localparam int REP_EN = 0;
`endif

    logic clk = 1'b0;
    logic resetn;
    logic clk_ms;
    int   cyc = 0;

    key_event_if bus();

    key_event_classifier #(
        .LONG_MS(10), .DOUBLE_MS(5), .REPEAT_MS(3), .CNT_W(16)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .clk_ms (clk_ms),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;
    assign clk_ms = (cyc % 20) >= 10;

    // pulse monitor
    int n_short = 0, n_double = 0, n_long = 0, n_repeat = 0, n_multi = 0;
    always @(negedge clk) begin
        if (bus.short_press)  n_short  <= n_short + 1;
        if (bus.double_press) n_double <= n_double + 1;
        if (bus.long_press)   n_long   <= n_long + 1;
        if (bus.repeat_press) n_repeat <= n_repeat + 1;
        if ($countones({bus.short_press, bus.double_press,
                        bus.long_press, bus.repeat_press}) > 1)
            n_multi <= n_multi + 1;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // advance to the next cycle in which the DUT sees an ms tick
    task automatic to_tick();
        do step(); while (cyc % 20 != 12);
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) to_tick();
        repeat (3) step();
    endtask

    task automatic drv(input logic p);
        bus.pressed = p;
        bus.change  = 1'b1;
        step();
        bus.change  = 1'b0;
    endtask

    task automatic align();
        to_tick();
        repeat (3) step();
    endtask

    typedef struct {
        int h1;      // ticks held on first press
        int gap;     // ticks released before second press (<0: none)
        int h2;      // ticks held on second press
        int e_short;
        int e_dbl;
        int e_long;
        int e_rep;
    } gest_t;

    gest_t vec[8];
    int b_s, b_d, b_l, b_r;

    initial begin
        vec[0] = '{3,  -1, 0,  1, 0, 0, 0};
        vec[1] = '{2,   2, 2,  0, 1, 0, 0};
        vec[2] = '{25, -1, 0,  0, 0, 1, 5 * REP_EN};
        vec[3] = '{2,   7, 2,  2, 0, 0, 0};
        vec[4] = '{1,   1, 12, 0, 1, 0, 0};
        vec[5] = '{9,  -1, 0,  1, 0, 0, 0};
        vec[6] = '{10, -1, 0,  0, 0, 1, 0};
        vec[7] = '{2,   4, 3,  0, 1, 0, 0};

        bus.pressed = 1'b0;
        bus.change  = 1'b0;
        resetn      = 1'b0;
        repeat (4) step();
        check("rst_state",  int'(bus.state), int'(IDLE));
        check("rst_short",  int'(bus.short_press), 0);
        check("rst_double", int'(bus.double_press), 0);
        check("rst_long",   int'(bus.long_press), 0);
        check("rst_repeat", int'(bus.repeat_press), 0);
        resetn = 1'b1;
        repeat (3) step();

        // table-driven gestures
        for (int i = 0; i < 8; i++) begin
            b_s = n_short; b_d = n_double; b_l = n_long; b_r = n_repeat;
            align();
            drv(1'b1);
            wait_ticks(vec[i].h1);
            drv(1'b0);
            if (vec[i].gap >= 0) begin
                wait_ticks(vec[i].gap);
                drv(1'b1);
                wait_ticks(vec[i].h2);
                drv(1'b0);
            end
            wait_ticks(8);
            check($sformatf("vec%0d_short", i),  n_short - b_s,  vec[i].e_short);
            check($sformatf("vec%0d_double", i), n_double - b_d, vec[i].e_dbl);
            check($sformatf("vec%0d_long", i),   n_long - b_l,   vec[i].e_long);
            check($sformatf("vec%0d_repeat", i), n_repeat - b_r, vec[i].e_rep);
            check($sformatf("vec%0d_state", i),  int'(bus.state), int'(IDLE));
        end

        // short press: pulse exactly on the cycle after the 5th tick after release
        align();
        drv(1'b1);
        wait_ticks(3);
        drv(1'b0);
        check("sp_wait2", int'(bus.state), int'(WAIT2));
        repeat (4) to_tick();
        to_tick();
        check("sp_before", int'(bus.short_press), 0);
        step();
        check("sp_pulse", int'(bus.short_press), 1);
        check("sp_idle",  int'(bus.state), int'(IDLE));
        step();
        check("sp_width", int'(bus.short_press), 0);

        // long hold with exact repeat positions
        align();
        b_l = n_long;
        drv(1'b1);
        repeat (9) to_tick();
        to_tick();
        check("lp_before", int'(bus.long_press), 0);
        step();
        check("lp_pulse", int'(bus.long_press), 1);
        check("lp_held",  int'(bus.state), int'(HELD));
        for (int k = 11; k <= 25; k++) begin
            to_tick();
            check($sformatf("rp_tick%0d_pre", k), int'(bus.repeat_press), 0);
            step();
            check($sformatf("rp_tick%0d", k), int'(bus.repeat_press),
                  (REP_EN != 0 && (k - 10) % 3 == 0) ? 1 : 0);
        end
        step();
        drv(1'b0);
        check("lp_rel_idle", int'(bus.state), int'(IDLE));
        check("lp_once", n_long - b_l, 1);

        // release coincides with the 10th tick: release wins, no long_press
        align();
        b_l = n_long;
        drv(1'b1);
        repeat (10) to_tick();
        drv(1'b0);
        check("tie_no_long", int'(bus.long_press), 0);
        check("tie_wait2",   int'(bus.state), int'(WAIT2));
        repeat (4) to_tick();
        to_tick();
        step();
        check("tie_short", int'(bus.short_press), 1);
        check("tie_long_cnt", n_long - b_l, 0);

        // reset in the middle of WAIT2
        align();
        b_s = n_short;
        drv(1'b1);
        wait_ticks(2);
        drv(1'b0);
        wait_ticks(2);
        check("mr_wait2", int'(bus.state), int'(WAIT2));
        #2 resetn = 1'b0;
        #1;
        check("mr_async_state", int'(bus.state), int'(IDLE));
        check("mr_async_short", int'(bus.short_press), 0);
        repeat (2) step();
        resetn = 1'b1;
        wait_ticks(8);
        check("mr_no_short", n_short - b_s, 0);

        // key already pressed when reset releases: no event
        b_s = n_short; b_d = n_double; b_l = n_long; b_r = n_repeat;
        resetn = 1'b0;
        bus.pressed = 1'b1;
        repeat (2) step();
        resetn = 1'b1;
        wait_ticks(12);
        check("pr_state", int'(bus.state), int'(IDLE));
        check("pr_events", (n_short - b_s) + (n_double - b_d)
                           + (n_long - b_l) + (n_repeat - b_r), 0);
        drv(1'b0);
        check("pr_rel_idle", int'(bus.state), int'(IDLE));

        // second press held: double_press at 10th tick, HELD, no long_press
        align();
        b_l = n_long;
        drv(1'b1);
        wait_ticks(1);
        drv(1'b0);
        wait_ticks(1);
        drv(1'b1);
        check("dh_press2", int'(bus.state), int'(PRESS2));
        repeat (9) to_tick();
        to_tick();
        check("dh_before", int'(bus.double_press), 0);
        step();
        check("dh_pulse", int'(bus.double_press), 1);
        check("dh_held",  int'(bus.state), int'(HELD));
        check("dh_nolong", int'(bus.long_press), 0);
        step();
        drv(1'b0);
        check("dh_idle", int'(bus.state), int'(IDLE));
        check("dh_long_cnt", n_long - b_l, 0);

        check("one_pulse_per_cycle", n_multi, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
